apb_cfg_regs: RTL and testbench

APB slave register block that terminates the aligner's APB bus and holds its configuration and status registers. It sits directly downstream of the APB interface bundle. It decodes each transfer, inserts a programmable number of wait states, and flags illegal accesses with `pslverr`. The core sees decoded register fields, and this block collects status and interrupt events from the core.

---
 rtl/apb_cfg_regs.sv | 124 ++++++++++++
 tb/tb_apb_cfg_regs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_regs.sv
// APB slave holding the aligner's CTRL/STATUS/IRQEN/IRQ registers, with programmable
// wait states, pslverr on illegal accesses, and an interrupt output.
module apb_cfg_regs #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [2:0]            ctrl_size,
  output logic [1:0]            ctrl_offset,
  output logic                  ctrl_clr,
  input  logic                  drop_pulse,
  input  logic [3:0]            rx_lvl,
  input  logic [3:0]            tx_lvl,
  input  logic [4:0]            irq_events,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state, next_state;
  logic [2:0]  cnt;
  logic [7:0]  cnt_drop;
  logic [4:0]  irqen, irq_reg, irq_clr;
  logic        is_ctrl, is_status, is_irqen, is_irq, mapped;
  logic        ctrl_legal, err, commit, wr_ok, clr_now;
  logic [2:0]  wsize;
  logic [1:0]  woff;
  logic [DATA_WIDTH-1:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{pwdata[DATA_WIDTH-1:17], pwdata[15:10], pwdata[7:5]};

  // SETUP is decoded from the bus in the same cycle so that ACCESS lines up with penable.
  always_comb begin
    state = state_q;
    if (state_q == IDLE && psel && !penable) state = SETUP;
    next_state = IDLE;
    case (state)
      SETUP:   next_state = ACCESS;
      ACCESS:  next_state = (pready || !psel) ? IDLE : ACCESS;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt     <= 3'd0;
    end else begin
      state_q <= next_state;
      if (state == SETUP) cnt <= 3'd0;
      else if (state == ACCESS && cnt < 3'(WAIT_STATES)) cnt <= cnt + 3'd1;
    end
  end

  assign pready = (state_q == ACCESS) && (cnt == 3'(WAIT_STATES));

  assign is_ctrl   = (paddr == ADDR_WIDTH'('h000));
  assign is_status = (paddr == ADDR_WIDTH'('h00C));
  assign is_irqen  = (paddr == ADDR_WIDTH'('h0F0));
  assign is_irq    = (paddr == ADDR_WIDTH'('h0F4));
  assign mapped    = is_ctrl | is_status | is_irqen | is_irq;

  // Only these SIZE/OFFSET pairs satisfy the alignment rules; SIZE=3 never does.
  assign wsize      = pwdata[2:0];
  assign woff       = pwdata[9:8];
  assign ctrl_legal = (wsize == 3'd1) ||
                      (wsize == 3'd2 && (woff == 2'd0 || woff == 2'd2)) ||
                      (wsize == 3'd4 && woff == 2'd0);

  assign err = (paddr[1:0] != 2'b00) || !mapped ||
               (pwrite && is_status) || (pwrite && is_ctrl && !ctrl_legal);

  assign commit  = psel && penable && pready;
  assign wr_ok   = commit && pwrite && !err;
  assign clr_now = wr_ok && is_ctrl && pwdata[16];
  assign irq_clr = (wr_ok && is_irq) ? pwdata[4:0] : 5'd0;

  always_comb begin
    rdata = '0;
    if (is_ctrl)   rdata = {22'd0, ctrl_offset, 5'd0, ctrl_size};
    if (is_status) rdata = {12'd0, tx_lvl, 4'd0, rx_lvl, cnt_drop};
    if (is_irqen)  rdata = {27'd0, irqen};
    if (is_irq)    rdata = {27'd0, irq_reg};
  end

  assign prdata  = (commit && !pwrite && !err) ? rdata : '0;
  assign pslverr = commit && err;

  // Register state; a CLR in the same cycle as a drop wins, an event wins over W1C.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ctrl_size   <= 3'd1;
      ctrl_offset <= 2'd0;
      ctrl_clr    <= 1'b0;
      cnt_drop    <= 8'd0;
      irqen       <= 5'd0;
      irq_reg     <= 5'd0;
    end else begin
      ctrl_clr <= clr_now;
      if (wr_ok && is_ctrl) begin
        ctrl_size   <= wsize;
        ctrl_offset <= woff;
      end
      if (wr_ok && is_irqen) irqen <= pwdata[4:0];
      irq_reg <= (irq_reg & ~irq_clr) | irq_events;
      if (clr_now) cnt_drop <= 8'd0;
      else if (drop_pulse && cnt_drop != 8'hFF) cnt_drop <= cnt_drop + 8'd1;
    end
  end

  assign irq = |(irq_reg & irqen);

endmodule

// File: tb/tb_apb_cfg_regs.sv
// Randomized scoreboard bench for apb_cfg_regs: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever a transfer completes.
module tb_apb_cfg_regs;
  localparam int WS = 1;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [2:0]  ctrl_size;
  logic [1:0]  ctrl_offset;
  logic        ctrl_clr, drop_pulse, irq;
  logic [3:0]  rx_lvl, tx_lvl;
  logic [4:0]  irq_events;

  apb_cfg_regs #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ctrl_size(ctrl_size), .ctrl_offset(ctrl_offset), .ctrl_clr(ctrl_clr),
    .drop_pulse(drop_pulse), .rx_lvl(rx_lvl), .tx_lvl(tx_lvl),
    .irq_events(irq_events), .irq(irq)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state, kept as plain integers.
  int m_size, m_off, m_irqen, m_irq, m_drop;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit legal(input int size, input int off);
    if (size < 1 || size > 4) return 1'b0;
    if (off + size > 4) return 1'b0;
    return ((4 + off) % size) == 0;
  endfunction

  task automatic reset_model();
    m_size = 1; m_off = 0; m_irqen = 0; m_irq = 0; m_drop = 0;
  endtask

  task automatic model_access(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                              output exp_t e, output bit clr);
    e = '0;
    clr = 1'b0;
    if (addr[1:0] != 2'b00) e.err = 1'b1;
    else if (addr == 16'h0000) begin
      if (!wr) e.rdata = 32'(m_size + m_off * 256);
      else if (legal(int'(data[2:0]), int'(data[9:8]))) begin
        m_size = int'(data[2:0]);
        m_off  = int'(data[9:8]);
        if (data[16]) begin m_drop = 0; clr = 1'b1; end
      end else e.err = 1'b1;
    end else if (addr == 16'h000C) begin
      if (wr) e.err = 1'b1;
      else e.rdata = 32'(m_drop + int'(rx_lvl) * 256 + int'(tx_lvl) * 65536);
    end else if (addr == 16'h00F0) begin
      if (wr) m_irqen = int'(data[4:0]);
      else e.rdata = 32'(m_irqen);
    end else if (addr == 16'h00F4) begin
      if (wr) m_irq = m_irq & ~int'(data[4:0]);
      else e.rdata = 32'(m_irq);
    end else e.err = 1'b1;
  endtask

  task automatic check_regs_out(input bit exp_clr);
    check_output("ctrl_size", 32'(ctrl_size), 32'(m_size));
    check_output("ctrl_offset", 32'(ctrl_offset), 32'(m_off));
    check_output("irq", 32'(irq), 32'((m_irq & m_irqen) != 0));
    check_output("ctrl_clr", 32'(ctrl_clr), 32'(exp_clr));
  endtask

  // One full APB transfer; optional core events are driven in the commit cycle.
  task automatic apply_stimulus(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                                input bit b2b = 1'b0, input bit ev_drop = 1'b0,
                                input logic [4:0] ev_irq = 5'd0);
    exp_t e;
    bit   clr;
    int   n;
    rx_lvl = 4'($urandom);
    tx_lvl = 4'($urandom);
    model_access(wr, addr, data, e, clr);
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    check_output("latency", 32'(n), 32'(WS));
    drop_pulse = ev_drop;
    irq_events = ev_irq;
    if (ev_drop && !clr && m_drop < 255) m_drop++;
    m_irq = m_irq | int'(ev_irq);
    @(posedge pclk); #1;
    drop_pulse = 1'b0; irq_events = 5'd0; penable = 1'b0;
    if (!b2b) psel = 1'b0;
    check_regs_out(clr);
    if (clr) begin
      psel = 1'b0;
      @(posedge pclk); #1;
      check_output("ctrl_clr_one_cycle", 32'(ctrl_clr), 32'd0);
    end
  endtask

  task automatic pulse_events(input bit d, input logic [4:0] ev);
    psel = 1'b0; penable = 1'b0;
    drop_pulse = d; irq_events = ev;
    if (d && m_drop < 255) m_drop++;
    m_irq = m_irq | int'(ev);
    @(posedge pclk); #1;
    drop_pulse = 1'b0; irq_events = 5'd0;
  endtask

  // Monitor: completions pop the scoreboard, all other cycles must show idle outputs.
  always @(negedge pclk) begin
    if (psel && penable && pready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_completion: got addr 0x%04h, expected none", paddr);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("prdata", prdata, mon_e.rdata);
        check_output("pslverr", 32'(pslverr), 32'(mon_e.err));
      end
    end else begin
      check_output("idle_prdata", prdata, 32'd0);
      check_output("idle_pslverr", 32'(pslverr), 32'd0);
    end
  end

  logic [15:0] addr_tab [8];
  logic [15:0] a;
  logic [31:0] d;

  initial begin
    addr_tab = '{16'h0000, 16'h000C, 16'h00F0, 16'h00F4, 16'h0004, 16'h0002, 16'h0100, 16'h00F1};
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    drop_pulse = 1'b0; rx_lvl = '0; tx_lvl = '0; irq_events = '0;
    reset_model();
    repeat (3) @(posedge pclk);
    #1;
    check_output("rst_pready", 32'(pready), 32'd0);
    check_output("rst_prdata", prdata, 32'd0);
    check_regs_out(1'b0);
    preset = 1'b0;
    @(posedge pclk); #1;

    apply_stimulus(1'b0, 16'h0000, 32'd0);
    apply_stimulus(1'b1, 16'h0000, 32'h0000_0202);
    apply_stimulus(1'b1, 16'h0000, 32'h0000_0102);

    for (int i = 0; i < 300; i++) pulse_events(1'b1, 5'd0);
    apply_stimulus(1'b0, 16'h000C, 32'd0);
    apply_stimulus(1'b1, 16'h0000, 32'h0001_0001);
    apply_stimulus(1'b0, 16'h000C, 32'd0);

    pulse_events(1'b0, 5'b00100);
    check_output("irq_masked", 32'(irq), 32'd0);
    apply_stimulus(1'b1, 16'h00F0, 32'h4);
    apply_stimulus(1'b1, 16'h00F4, 32'h4, 1'b0, 1'b1, 5'b00100);
    apply_stimulus(1'b0, 16'h00F4, 32'd0);
    apply_stimulus(1'b1, 16'h00F4, 32'h4);
    apply_stimulus(1'b0, 16'h000C, 32'd0);

    apply_stimulus(1'b0, 16'h0004, 32'd0);
    apply_stimulus(1'b0, 16'h0002, 32'd0);
    apply_stimulus(1'b1, 16'h000C, 32'hFFFF_FFFF);

    // Abort: psel drops in the cycle that would have completed.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h0001_0004;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    check_output("abort_pready", 32'(pready), 32'd0);
    check_regs_out(1'b0);
    apply_stimulus(1'b0, 16'h0000, 32'd0);

    // Reset while pready is high: it must drop before the next edge.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h0000_0004;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check_output("pre_reset_pready", 32'(pready), 32'd1);
    #2 preset = 1'b1;
    #1 check_output("async_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    reset_model();
    check_regs_out(1'b0);
    apply_stimulus(1'b0, 16'h0000, 32'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 3) pulse_events(1'($urandom_range(0, 1)), 5'($urandom));
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addr_tab[$urandom_range(0, 7)];
      d = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0001_0317);
      apply_stimulus(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0);
    end

    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
